// File: rtl/boot_loader_pkg.sv
// Shared constants for the boot loader: load-FSM state encodings, stream
// byte geometry and the image-length acceptance rule.
package boot_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTE_CNT_W     = 2;
    localparam int WORDS_LOADED_W = 7;

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE_IDX = 2'd3;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } load_state_e;

    // Zero-length images and images larger than the memory window are rejected.
    function automatic logic len_ok(input logic [BYTE_W-1:0] n, input int unsigned max_words);
        return (n != '0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/boot_loader_byte_word_packer.sv
// Packs a big-endian byte stream into words: shift register, byte counter
// and a flag that fires on the transfer completing a word.
module byte_word_packer
    import boot_loader_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [BYTE_W-1:0]    byte_in,
    output logic [WORD_SIZE-1:0] word_next,
    output logic                 word_complete
);

    logic [WORD_SIZE-1:0]  word_q, word_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        word_next     = {word_q[WORD_SIZE-BYTE_W-1:0], byte_in};
        word_d        = word_q;
        cnt_d         = cnt_q;
        word_complete = 1'b0;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d        = word_next;
            cnt_d         = cnt_q + 1'b1;
            word_complete = (cnt_q == LAST_BYTE_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// while holding the processor in reset; releases it once the image verifies.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart,
    input  logic [BYTE_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      mem_write_en,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [WORD_SIZE-1:0]      mem_write_data,
    output logic                      cpu_hold,
    output logic                      load_done,
    output logic                      load_error,
    output logic [WORDS_LOADED_W-1:0] words_loaded
);

    load_state_e               state_q, state_d;
    logic [BYTE_W-1:0]         len_q, len_d;
    logic [BYTE_W-1:0]         csum_q, csum_d;
    logic [WORDS_LOADED_W-1:0] words_q, words_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [WORD_SIZE-1:0]      wdata_q, wdata_d;
    logic                      wen_q, wen_d;
    logic                      ready_q, ready_d;
    logic                      hold_q, hold_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      xfer;
    logic [WORD_SIZE-1:0]      word_next;
    logic                      word_complete;

    assign xfer = in_valid && ready_q;

    byte_word_packer #(
        .WORD_SIZE(WORD_SIZE)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_q == ST_LEN),
        .shift_en     (xfer && (state_q == ST_DATA)),
        .byte_in      (in_data),
        .word_next    (word_next),
        .word_complete(word_complete)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        words_d = words_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_LEN: begin
                if (xfer) begin
                    len_d   = in_data;
                    csum_d  = in_data;
                    state_d = len_ok(in_data, MAX_WORDS) ? ST_DATA : ST_ERROR;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    if (word_complete) begin
                        // Latch address and word on WRITE entry so they hold afterwards.
                        state_d = ST_WRITE;
                        addr_d  = ADDR_WIDTH'({words_q, 2'b00});
                        wdata_d = word_next;
                    end
                end
            end
            ST_WRITE: begin
                words_d = words_q + 1'b1;
                state_d = ({1'b0, words_d} == len_q) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_d = ST_LEN;
                    words_d = '0;
                    csum_d  = '0;
                end
            end
            default: state_d = ST_ERROR;
        endcase

        // Outputs decode the next state so they are registered yet aligned with it.
        ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHECK);
        wen_d   = (state_d == ST_WRITE);
        hold_d  = (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LEN;
            len_q   <= '0;
            csum_q  <= '0;
            words_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready       = ready_q;
    assign mem_write_en   = wen_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign cpu_hold       = hold_q;
    assign load_done      = done_q;
    assign load_error     = err_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: reset values, single/multi-word loads,
// length and checksum errors, restart, maximum image and mid-load reset.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_write_en;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [6:0]  words_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  wr_addr_log [0:255];
    logic [31:0] wr_data_log [0:255];
    int          wr_count    = 0;
    int          wr_rdy_bad  = 0;

    boot_loader #(
        .WORD_SIZE (32),
        .ADDR_WIDTH(8),
        .MAX_WORDS (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_write_en  (mem_write_en),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle; every strobe must coincide with in_ready low.
    always @(negedge clk) begin
        if (mem_write_en) begin
            if (wr_count < 256) begin
                wr_addr_log[wr_count] = mem_address;
                wr_data_log[wr_count] = mem_write_data;
            end
            wr_count = wr_count + 1;
            if (in_ready) wr_rdy_bad = wr_rdy_bad + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1 (byte %h)", in_ready, b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        vectors++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 ||
            words_loaded !== 7'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_state: hold=%b done=%b err=%b words=%0d rdy=%b required 1 0 0 0 1",
                     cpu_hold, load_done, load_error, words_loaded, in_ready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        vectors++;
        if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b required 0", mem_write_en); end
        vectors++;
        if (mem_address !== 8'h00 || mem_write_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_mem_bus: addr=%h data=%h required 00 00000000", mem_address, mem_write_data);
        end
        vectors++;
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold: got %b required 1", cpu_hold); end
        vectors++;
        if (load_done !== 1'b0 || load_error !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: done=%b err=%b required 0 0", load_done, load_error);
        end
        vectors++;
        if (words_loaded !== 7'd0) begin miscompares++; $display("FAIL reset_words: got %0d required 0", words_loaded); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_word();
        int base;
        base = wr_count;
        send_byte(8'h01, 0);
        send_word(32'h20080005, 0);
        send_byte(8'h2C, 0);
        vectors++;
        if (wr_count - base !== 1) begin miscompares++; $display("FAIL single_write_count: got %0d required 1", wr_count - base); end
        vectors++;
        if (wr_addr_log[base] !== 8'h00 || wr_data_log[base] !== 32'h20080005) begin
            miscompares++; $display("FAIL single_write: addr=%h data=%h required 00 20080005", wr_addr_log[base], wr_data_log[base]);
        end
        vectors++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_error !== 1'b0) begin
            miscompares++; $display("FAIL single_done: done=%b hold=%b err=%b required 1 0 0", load_done, cpu_hold, load_error);
        end
        vectors++;
        if (words_loaded !== 7'd1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL single_words: words=%0d rdy=%b required 1 0", words_loaded, in_ready);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_address !== 8'h00 || mem_write_data !== 32'h20080005 || mem_write_en !== 1'b0 || load_done !== 1'b1) begin
            miscompares++; $display("FAIL single_hold: addr=%h data=%h wen=%b done=%b required 00 20080005 0 1",
                                    mem_address, mem_write_data, mem_write_en, load_done);
        end
        do_restart();
    endtask

    task automatic test_gapped_stream();
        int base;
        int bad0;
        base = wr_count;
        bad0 = wr_rdy_bad;
        send_byte(8'h03, $urandom_range(1, 9));
        send_word(32'h11223344, $urandom_range(1, 9));
        send_word(32'h55667788, $urandom_range(1, 9));
        send_word(32'h99AABBCC, $urandom_range(1, 9));
        send_byte(8'hCF, 9);
        vectors++;
        if (wr_count - base !== 3) begin miscompares++; $display("FAIL gap_write_count: got %0d required 3", wr_count - base); end
        vectors++;
        if (wr_addr_log[base] !== 8'h00 || wr_data_log[base] !== 32'h11223344 ||
            wr_addr_log[base+1] !== 8'h04 || wr_data_log[base+1] !== 32'h55667788 ||
            wr_addr_log[base+2] !== 8'h08 || wr_data_log[base+2] !== 32'h99AABBCC) begin
            miscompares++; $display("FAIL gap_writes: %h/%h %h/%h %h/%h required 00/11223344 04/55667788 08/99AABBCC",
                                    wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1],
                                    wr_addr_log[base+2], wr_data_log[base+2]);
        end
        vectors++;
        if (wr_rdy_bad !== bad0) begin miscompares++; $display("FAIL gap_ready_during_write: got %0d required 0", wr_rdy_bad - bad0); end
        vectors++;
        if (load_done !== 1'b1 || words_loaded !== 7'd3) begin
            miscompares++; $display("FAIL gap_done: done=%b words=%0d required 1 3", load_done, words_loaded);
        end
        do_restart();
    endtask

    task automatic test_zero_length();
        int base;
        base = wr_count;
        send_byte(8'h00, 0);
        vectors++;
        if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL zero_len_error: err=%b hold=%b done=%b rdy=%b required 1 1 0 0",
                                    load_error, cpu_hold, load_done, in_ready);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_count !== base || load_error !== 1'b1) begin
            miscompares++; $display("FAIL zero_len_nowrite: writes=%0d err=%b required 0 1", wr_count - base, load_error);
        end
        do_restart();
    endtask

    task automatic test_max_length();
        int          base;
        logic [7:0]  csum;
        logic [7:0]  i8;
        send_byte(8'h41, 0);
        vectors++;
        if (load_error !== 1'b1 || cpu_hold !== 1'b1) begin
            miscompares++; $display("FAIL len65_error: err=%b hold=%b required 1 1", load_error, cpu_hold);
        end
        do_restart();
        base = wr_count;
        csum = 8'h40;
        send_byte(8'h40, 0);
        for (int i = 0; i < 64; i++) begin
            i8 = 8'(i);
            send_word({i8, 8'hFF - i8, 8'h3C, i8 + 8'h80}, 0);
            csum = csum ^ i8 ^ (8'hFF - i8) ^ 8'h3C ^ (i8 + 8'h80);
        end
        send_byte(csum, 0);
        vectors++;
        if (wr_count - base !== 64) begin miscompares++; $display("FAIL len64_count: got %0d required 64", wr_count - base); end
        vectors++;
        if (wr_addr_log[base+16] !== 8'h40 || wr_data_log[base+16] !== 32'h10EF3C90) begin
            miscompares++; $display("FAIL len64_mid: addr=%h data=%h required 40 10EF3C90", wr_addr_log[base+16], wr_data_log[base+16]);
        end
        vectors++;
        if (wr_addr_log[base+63] !== 8'hFC || wr_data_log[base+63] !== 32'h3FC03CBF) begin
            miscompares++; $display("FAIL len64_last: addr=%h data=%h required FC 3FC03CBF", wr_addr_log[base+63], wr_data_log[base+63]);
        end
        vectors++;
        if (load_done !== 1'b1 || words_loaded !== 7'd64 || cpu_hold !== 1'b0) begin
            miscompares++; $display("FAIL len64_done: done=%b words=%0d hold=%b required 1 64 0", load_done, words_loaded, cpu_hold);
        end
        do_restart();
    endtask

    task automatic test_bad_checksum();
        send_byte(8'h01, 0);
        send_word(32'h20080005, 0);
        send_byte(8'h0D, 0);
        vectors++;
        if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            miscompares++; $display("FAIL badsum_error: err=%b hold=%b done=%b required 1 1 0", load_error, cpu_hold, load_done);
        end
        do_restart();
        send_byte(8'h01, 0);
        send_word(32'h20080005, 0);
        send_byte(8'h2C, 0);
        vectors++;
        if (load_done !== 1'b1 || words_loaded !== 7'd1 || load_error !== 1'b0 || cpu_hold !== 1'b0) begin
            miscompares++; $display("FAIL badsum_reload: done=%b words=%0d err=%b hold=%b required 1 1 0 0",
                                    load_done, words_loaded, load_error, cpu_hold);
        end
        do_restart();
    endtask

    task automatic test_reset_midload();
        int base;
        send_byte(8'h04, 0);
        send_word(32'hA1A2A3A4, 0);
        send_word(32'hB1B2B3B4, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if (words_loaded !== 7'd2 || mem_address !== 8'h04) begin
            miscompares++; $display("FAIL midload_progress: words=%0d addr=%h required 2 04", words_loaded, mem_address);
        end
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || mem_write_en !== 1'b0 || mem_address !== 8'h00 || mem_write_data !== 32'h0 ||
            cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || words_loaded !== 7'd0) begin
            miscompares++; $display("FAIL midload_async_reset: rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b words=%0d required 1 0 00 00000000 1 0 0 0",
                                    in_ready, mem_write_en, mem_address, mem_write_data, cpu_hold, load_done, load_error, words_loaded);
        end
        #5;
        rst = 1'b1;
        base = wr_count;
        send_byte(8'h02, 0);
        send_word(32'hCAFEBABE, 0);
        send_word(32'h12345678, 0);
        send_byte(8'h3A, 0);
        vectors++;
        if (wr_count - base !== 2 || wr_addr_log[base] !== 8'h00 || wr_data_log[base] !== 32'hCAFEBABE ||
            wr_addr_log[base+1] !== 8'h04 || wr_data_log[base+1] !== 32'h12345678) begin
            miscompares++; $display("FAIL midload_fresh_writes: n=%0d %h/%h %h/%h required 2 00/CAFEBABE 04/12345678",
                                    wr_count - base, wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1]);
        end
        vectors++;
        if (load_done !== 1'b1 || words_loaded !== 7'd2 || cpu_hold !== 1'b0) begin
            miscompares++; $display("FAIL midload_fresh_done: done=%b words=%0d hold=%b required 1 2 0", load_done, words_loaded, cpu_hold);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gapped_stream();
        test_zero_length();
        test_max_length();
        test_bad_checksum();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
